uart_tx_param: RTL and testbench

- Parametrised UART transmitter that succeeds the fixed 8E1 transmitter.
- Configurable data width, parity mode and stop-bit count; the baud divider is internal.
- Uses a valid/ready input handshake and a registered serial output.
- Sits between a byte/word producer (CPU bridge, FIFO) and the board TX pin.

---
 rtl/uart_tx_param_if.sv | 21 ++
 rtl/uart_tx_param.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Producer-side valid/ready handshake for uart_tx_param.
// Ports: s_valid, s_data (DATA_BITS), s_ready; master=producer, slave=transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_valid;
  logic [DATA_BITS-1:0] s_data;
  logic                 s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: START, DATA (LSB first), optional PARITY, STOP.
// Ports: clk, rst (sync, active high), s (slave handshake), tx, busy, frame_done.
// Optional macro UART_TX_HOLD_EN adds a one-entry holding register.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_param_if.slave  s,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY_MODE == 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_pm
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, ld_data;
  logic                 par_q, par_d;
  logic                 xfer, last_baud, frame_end, load;
  logic                 ready_d, tx_d, fd_d;
`ifdef UART_TX_HOLD_EN
  logic                 hold_q, hold_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
`endif

  assign xfer      = s.s_valid && s.s_ready;
  assign last_baud = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    frame_end = 1'b0;
    load      = 1'b0;
    ld_data   = s.s_data;
`ifdef UART_TX_HOLD_EN
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
`endif
    if (state_q != IDLE) begin
      baud_d = last_baud ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      IDLE: ;
      START: begin
        if (last_baud) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (last_baud) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_baud) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (last_baud) begin
          if (bit_q == STOP_LAST) begin
            state_d   = IDLE;
            frame_end = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_HOLD_EN
    // A held word chains straight into START with no idle cycle.
    if (frame_end && hold_q) begin
      load    = 1'b1;
      ld_data = hold_data_q;
      hold_d  = 1'b0;
    end else if (xfer && (state_q == IDLE || frame_end)) begin
      load = 1'b1;
    end else if (xfer) begin
      hold_d      = 1'b1;
      hold_data_d = s.s_data;
    end
`else
    load = xfer;
`endif
    if (load) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = ld_data;
      par_d   = (^ld_data) ^ PAR_INV;
    end
`ifdef UART_TX_HOLD_EN
    ready_d = !hold_d;
`else
    ready_d = (state_d == IDLE);
`endif
    // Outputs are registered from the next-state view.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    fd_d = (state_d == STOP) && (bit_d == STOP_LAST) &&
           (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      s.s_ready  <= 1'b1;
`ifdef UART_TX_HOLD_EN
      hold_q      <= 1'b0;
      hold_data_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx         <= tx_d;
      busy       <= (state_d != IDLE);
      frame_done <= fd_d;
      s.s_ready  <= ready_d;
`ifdef UART_TX_HOLD_EN
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: four configurations checked bit-by-bit
// against a frame model built from the framing rules.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] vld = '0;
  logic [8:0] dat [4];
  logic [3:0] tx_w, busy_w, fd_w, rdy_w;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  int db [4] = '{8, 8, 8, 7};
  int pm [4] = '{1, 2, 0, 1};
  int sb [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();

  assign if0.s_valid = vld[0];
  assign if1.s_valid = vld[1];
  assign if2.s_valid = vld[2];
  assign if3.s_valid = vld[3];
  assign if0.s_data  = dat[0][7:0];
  assign if1.s_data  = dat[1][7:0];
  assign if2.s_data  = dat[2][7:0];
  assign if3.s_data  = dat[3][6:0];
  assign rdy_w[0]    = if0.s_ready;
  assign rdy_w[1]    = if1.s_ready;
  assign rdy_w[2]    = if2.s_ready;
  assign rdy_w[3]    = if3.s_ready;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .s(if0.slave),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .s(if1.slave),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .s(if2.slave),
    .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7),
    .PARITY_MODE(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .s(if3.slave),
    .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbits(input int idx);
    return 1 + db[idx] + ((pm[idx] != 0) ? 1 : 0) + sb[idx];
  endfunction

  // Bit k of the frame: start, payload LSB first, parity, stop(s).
  function automatic logic exp_bit(input int idx, input logic [8:0] d,
                                   input int k);
    logic p;
    if (k == 0) return 1'b0;
    if (k <= db[idx]) return d[k-1];
    if (pm[idx] != 0 && k == db[idx] + 1) begin
      p = (pm[idx] == 2);
      for (int i = 0; i < db[idx]; i++) p = p ^ d[i];
      return p;
    end
    return 1'b1;
  endfunction

  // Called #1 after the transfer edge; leaves off #1 after the edge
  // that ends the frame.
  task automatic check_frame(input int idx, input logic [8:0] d,
                             input int pulse_at, input logic [8:0] pd);
    int len;
    len = nbits(idx) * CPB;
    for (int c = 1; c <= len; c++) begin
      chk($sformatf("tx%0d_c%0d", idx, c), 32'(tx_w[idx]),
          32'(exp_bit(idx, d, (c - 1) / CPB)));
      chk($sformatf("fd%0d_c%0d", idx, c), 32'(fd_w[idx]),
          32'(c == len));
      chk($sformatf("busy%0d_c%0d", idx, c), 32'(busy_w[idx]), 32'd1);
`ifndef UART_TX_HOLD_EN
      chk($sformatf("rdy%0d_c%0d", idx, c), 32'(rdy_w[idx]), 32'd0);
`endif
      if (c == pulse_at) begin
        vld[idx] = 1'b1;
        dat[idx] = pd;
      end else if (c == pulse_at + 1) begin
        vld[idx] = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while (rdy_w[idx] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("ready_wait%0d", idx), 32'(n < 200), 32'd1);
  endtask

  task automatic post_idle(input int idx);
    chk($sformatf("idle_tx%0d", idx), 32'(tx_w[idx]), 32'd1);
    chk($sformatf("idle_busy%0d", idx), 32'(busy_w[idx]), 32'd0);
    chk($sformatf("idle_rdy%0d", idx), 32'(rdy_w[idx]), 32'd1);
  endtask

  task automatic send(input int idx, input logic [8:0] d,
                      input int pulse_at, input logic [8:0] pd);
    dat[idx] = d;
    vld[idx] = 1'b1;
    wait_ready(idx);
    @(posedge clk); #1;
    vld[idx] = 1'b0;
    dat[idx] = ~d;
    check_frame(idx, d, pulse_at, pd);
    post_idle(idx);
  endtask

  initial begin
    int idx, fd_seen;
    logic [8:0] d;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(tx_w[i]), 32'd1);
      chk($sformatf("rst_rdy%0d", i), 32'(rdy_w[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("rst_fd%0d", i), 32'(fd_w[i]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    send(0, 9'h0A5, -5, 9'h0);
    send(1, 9'h000, -5, 9'h0);
    send(2, 9'h0FF, -5, 9'h0);
    send(3, 9'h041, -5, 9'h0);

    for (int n = 0; n < 8; n++) begin
      idx = int'($urandom_range(0, 3));
      d = 9'($urandom) & 9'((1 << db[idx]) - 1);
      send(idx, d, -5, 9'h0);
    end

    // Back-to-back words with s_valid held.
`ifdef UART_TX_HOLD_EN
    dat[0] = 9'h055;
    vld[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    check_frame(0, 9'h055, 1, 9'h033);
    check_frame(0, 9'h033, -5, 9'h0);
    post_idle(0);
`else
    dat[0] = 9'h055;
    vld[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    dat[0] = 9'h033;
    check_frame(0, 9'h055, -5, 9'h0);
    post_idle(0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    check_frame(0, 9'h033, -5, 9'h0);
    post_idle(0);
`endif

`ifndef UART_TX_HOLD_EN
    // Word offered while busy must be dropped.
    send(0, 9'h03C, 10, 9'h0FF);
    fd_seen = 0;
    for (int n = 0; n < 50; n++) begin
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) fd_seen = 1;
      @(posedge clk); #1;
    end
    chk("ignored_word_quiet", 32'(fd_seen), 32'd0);
`endif

    // Reset during the third data bit.
    dat[0] = 9'h0C3;
    vld[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_tx", 32'(tx_w[0]), 32'(exp_bit(0, 9'h0C3, 3)));
    chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_rst_rdy", 32'(rdy_w[0]), 32'd1);
    chk("mid_rst_fd", 32'(fd_w[0]), 32'd0);
    fd_seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (fd_w[0] !== 1'b0 || tx_w[0] !== 1'b1) fd_seen = 1;
      @(posedge clk); #1;
    end
    chk("abandoned_no_fd", 32'(fd_seen), 32'd0);
    send(0, 9'h00F, -5, 9'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
